// File: rtl/dcnn_pkg.sv
// Shared definitions for the parameter-load path.
// Holds the load-controller state encoding, the byte offsets of the RAM
// header fields relative to the header base address, and the word size.
// No ports; import with "import dcnn_pkg::*;".
package dcnn_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_RD,
        S_READY,
        S_WR_HI,
        S_WR_LO,
        S_DONE,
        S_ERR
    } plcState_t;

    // Header layout, relative to the header base address.
    localparam int NLAYERS = 0;
    localparam int FOFF_HI = 1;
    localparam int FOFF_LO = 2;
    localparam int DOFF_HI = 3;
    localparam int DOFF_LO = 4;

    localparam int BYTES_PER_WORD = 2;

    // Layer count byte plus two big-endian offsets.
    localparam int HDR_BYTES = 1 + 2 * BYTES_PER_WORD;

endpackage

// File: rtl/param_load_controller_hdr_reader.sv
// hdr_reader: pipelined fetch of the 5-byte parameter RAM header.
// A one-cycle start pulse issues reads at HDR_BASE..HDR_BASE+4 on five
// consecutive cycles; each byte is captured the cycle after its read, so the
// whole fetch takes six cycles. done is high during the sixth cycle, while
// the last byte (dense offset low) is still on rdata; denseOff folds that
// byte in directly so the caller can latch everything on that edge.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         begin a fetch (ignored while abort is high)
//   abort         cancel a fetch in progress
//   rdata         RAM read byte, valid one cycle after rd
//   rd, addr      RAM read strobe and address (registered)
//   done          last header byte is on rdata this cycle
//   numLayers     latched layer count
//   filtOff       filter region offset {hi, lo}
//   denseOff      dense region offset {hi, rdata}; valid while done is high
module hdr_reader
    import dcnn_pkg::*;
#(
    parameter int HDR_BASE = 1,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        rdata,
    output logic              rd,
    output logic [ADDR_W-1:0] addr,
    output logic              done,
    output logic [7:0]        numLayers,
    output logic [15:0]       filtOff,
    output logic [15:0]       denseOff
);

    // step counts the fetch cycles 1..LAST_STEP; 0 means idle. During step k
    // the byte read in step k-1 is on rdata, i.e. header byte k-2.
    localparam logic [2:0] LAST_STEP = 3'(DOFF_LO + 2);

    logic [2:0] step;
    logic [2:0] capIdx;
    logic [7:0] filtHi;
    logic [7:0] filtLo;
    logic [7:0] denseHi;

    assign capIdx   = step - 3'd2;
    assign done     = (step == LAST_STEP);
    assign filtOff  = {filtHi, filtLo};
    assign denseOff = {denseHi, rdata};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step      <= 3'd0;
            rd        <= 1'b0;
            addr      <= '0;
            numLayers <= 8'd0;
            filtHi    <= 8'd0;
            filtLo    <= 8'd0;
            denseHi   <= 8'd0;
        end else if (abort) begin
            step <= 3'd0;
            rd   <= 1'b0;
            addr <= '0;
        end else if (start) begin
            step <= 3'd1;
            rd   <= 1'b1;
            addr <= ADDR_W'(HDR_BASE);
        end else if (step != 3'd0) begin
            if (step < 3'(HDR_BYTES)) begin
                rd   <= 1'b1;
                addr <= addr + ADDR_W'(1);
            end else begin
                rd   <= 1'b0;
                addr <= '0;
            end
            step <= (step == LAST_STEP) ? 3'd0 : step + 3'd1;
            if (step >= 3'd2) begin
                case (capIdx)
                    3'(NLAYERS): numLayers <= rdata;
                    3'(FOFF_HI): filtHi    <= rdata;
                    3'(FOFF_LO): filtLo    <= rdata;
                    3'(DOFF_HI): denseHi   <= rdata;
                    default:     ;
                endcase
            end
        end
    end

endmodule

// File: rtl/param_load_controller.sv
// param_load_controller: sequences the parameter-load phase.
// On a rising edge of (load && cnn) it fetches the RAM header, then turns
// each accepted 16-bit host word into two byte writes (high byte first) at
// auto-incrementing addresses starting at the filter offset. Tracks the
// conv-to-dense boundary, counts words, pulses param_done when the phase
// ends and flags writes that would run past the top of the address space.
// Ports:
//   clk, RST                  clock, asynchronous active-high reset
//   load, cnn                 phase active / parameter (1) vs image (0) load
//   Din, din_valid, din_ready host word input
//   ram_addr, ram_wdata       RAM address and write byte
//   ram_rdata                 RAM read byte, valid one cycle after ram_rd
//   ram_rd, ram_wr            RAM strobes
//   num_layers                header layer count
//   in_dense                  write pointer has reached the dense offset
//   words_written             accepted words this phase (wraps)
//   param_done                one-cycle pulse at end of phase
//   err_overflow              sticky address-space overflow flag
//   dbgState                  current FSM state
//
// Host handshake: a word is transferred on a rising clock edge where
// din_ready and din_valid are both 1. din_ready is high only in READY, and
// din_valid while din_ready is 0 is dropped, not queued; the host must hold
// Din stable for the transfer edge only (the word is registered there).
module param_load_controller
    import dcnn_pkg::*;
#(
    parameter int HDR_BASE = 1,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              load,
    input  logic              cnn,
    input  logic [15:0]       Din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [7:0]        num_layers,
    output logic              in_dense,
    output logic [15:0]       words_written,
    output logic              param_done,
    output logic              err_overflow,
    output plcState_t         dbgState
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    plcState_t         state;
    logic [ADDR_W-1:0] wp;
    logic [ADDR_W-1:0] wpNext;
    logic [ADDR_W-1:0] denseOff;
    logic [ADDR_W-1:0] wrAddr;
    logic [ADDR_W-1:0] hdrAddr;
    logic [15:0]       dataQ;
    logic [15:0]       hdrFiltOff;
    logic [15:0]       hdrDenseOff;
    logic              loadDrop;
    logic              lcQ;
    logic              lcQ2;
    logic              active;
    logic              hdrStart;
    logic              hdrAbort;
    logic              hdrDone;

    // cnn dropping while busy behaves exactly like load dropping.
    assign active   = load & cnn;
    assign hdrStart = (state == S_IDLE) && lcQ && !lcQ2;
    assign hdrAbort = (state == S_HDR_RD) && !active;
    assign wpNext   = wp + ADDR_W'(1);
    assign ram_addr = (state == S_HDR_RD) ? hdrAddr : wrAddr;
    assign dbgState = state;

    hdr_reader #(
        .HDR_BASE (HDR_BASE),
        .ADDR_W   (ADDR_W)
    ) u_hdr (
        .clk       (clk),
        .rst       (RST),
        .start     (hdrStart),
        .abort     (hdrAbort),
        .rdata     (ram_rdata),
        .rd        (ram_rd),
        .addr      (hdrAddr),
        .done      (hdrDone),
        .numLayers (num_layers),
        .filtOff   (hdrFiltOff),
        .denseOff  (hdrDenseOff)
    );

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state         <= S_IDLE;
            wp            <= '0;
            denseOff      <= '0;
            wrAddr        <= '0;
            dataQ         <= 16'd0;
            loadDrop      <= 1'b0;
            lcQ           <= 1'b0;
            lcQ2          <= 1'b0;
            din_ready     <= 1'b0;
            ram_wr        <= 1'b0;
            ram_wdata     <= 8'd0;
            in_dense      <= 1'b0;
            words_written <= 16'd0;
            param_done    <= 1'b0;
            err_overflow  <= 1'b0;
        end else begin
            // Registered copy of the phase condition plus one more stage
            // for its rising-edge detect.
            lcQ        <= active;
            lcQ2       <= lcQ;
            param_done <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (hdrStart) begin
                        state         <= S_HDR_RD;
                        words_written <= 16'd0;
                        in_dense      <= 1'b0;
                        loadDrop      <= 1'b0;
                    end
                end

                S_HDR_RD: begin
                    if (!active) begin
                        state      <= S_DONE;
                        param_done <= 1'b1;
                    end else if (hdrDone) begin
                        state     <= S_READY;
                        din_ready <= 1'b1;
                        wp        <= ADDR_W'(hdrFiltOff);
                        denseOff  <= ADDR_W'(hdrDenseOff);
                        in_dense  <= (hdrFiltOff >= hdrDenseOff);
                    end
                end

                S_READY: begin
                    if (din_valid) begin
                        // din_ready is high here, so this word is owed a
                        // full write even if the phase ends this cycle.
                        state     <= S_WR_HI;
                        dataQ     <= Din;
                        din_ready <= 1'b0;
                        ram_wr    <= 1'b1;
                        wrAddr    <= wp;
                        ram_wdata <= Din[15:8];
                        loadDrop  <= !active;
                    end else if (!active) begin
                        state      <= S_DONE;
                        din_ready  <= 1'b0;
                        param_done <= 1'b1;
                    end
                end

                S_WR_HI: begin
                    wp       <= wpNext;
                    loadDrop <= loadDrop | !active;
                    if (wpNext == denseOff) begin
                        in_dense <= 1'b1;
                    end
                    if (wp == ADDR_MAX) begin
                        // High byte landed at the last address; the low
                        // byte has nowhere to go.
                        state        <= S_ERR;
                        ram_wr       <= 1'b0;
                        err_overflow <= 1'b1;
                    end else begin
                        state     <= S_WR_LO;
                        wrAddr    <= wpNext;
                        ram_wdata <= dataQ[7:0];
                    end
                end

                S_WR_LO: begin
                    wp            <= wpNext;
                    ram_wr        <= 1'b0;
                    words_written <= words_written + 16'd1;
                    if (wpNext == denseOff) begin
                        in_dense <= 1'b1;
                    end
                    if (loadDrop || !active) begin
                        state      <= S_DONE;
                        param_done <= 1'b1;
                    end else if (wp == ADDR_MAX) begin
                        // Address space exhausted while the host is still
                        // loading: any further byte would wrap to 0.
                        state        <= S_ERR;
                        err_overflow <= 1'b1;
                    end else begin
                        state     <= S_READY;
                        din_ready <= 1'b1;
                    end
                end

                S_ERR: begin
                    if (!active) begin
                        state      <= S_DONE;
                        param_done <= 1'b1;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_param_load_controller.sv
// Directed bench for param_load_controller with a behavioural byte RAM.
// Every RAM write is compared against an expected queue of {addr, data}.
module tb_param_load_controller;
    import dcnn_pkg::*;

    localparam int ADDR_W   = 16;
    localparam int HDR_BASE = 1;
    localparam int WAIT_MAX = 40;

    logic              clk = 1'b0;
    logic              RST;
    logic              load;
    logic              cnn;
    logic [15:0]       Din;
    logic              din_valid;
    logic              din_ready;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_wdata;
    logic [7:0]        ram_rdata;
    logic              ram_rd;
    logic              ram_wr;
    logic [7:0]        num_layers;
    logic              in_dense;
    logic [15:0]       words_written;
    logic              param_done;
    logic              err_overflow;
    plcState_t         dbgState;

    int checks = 0;
    int errors = 0;

    logic [23:0] exp_q[$];
    logic [15:0] rdSeq[$];
    logic [15:0] expWp;

    // Clock / reset
    always #5 clk = ~clk;

    param_load_controller #(
        .HDR_BASE (HDR_BASE),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk           (clk),
        .RST           (RST),
        .load          (load),
        .cnn           (cnn),
        .Din           (Din),
        .din_valid     (din_valid),
        .din_ready     (din_ready),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .ram_rd        (ram_rd),
        .ram_wr        (ram_wr),
        .num_layers    (num_layers),
        .in_dense      (in_dense),
        .words_written (words_written),
        .param_done    (param_done),
        .err_overflow  (err_overflow),
        .dbgState      (dbgState)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // RAM model and write scoreboard
    logic [7:0]  mem [0:65535];
    logic        pokeEn;
    logic [15:0] pokeAddr;
    logic [7:0]  pokeData;

    always @(posedge clk) begin
        if (pokeEn) mem[pokeAddr] <= pokeData;
        if (ram_rd) ram_rdata <= mem[ram_addr];
        if (ram_wr) begin
            mem[ram_addr] <= ram_wdata;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_write observed=0x%0h/0x%0h expected=none", ram_addr, ram_wdata);
            end else begin
                check("ram_write", {8'h00, ram_addr, ram_wdata}, {8'h00, exp_q.pop_front()});
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        pokeAddr = a;
        pokeData = d;
        pokeEn   = 1'b1;
        tick();
        pokeEn   = 1'b0;
    endtask

    // Raise load/cnn and wait for din_ready; load registers on the first
    // edge, then six header cycles, so din_ready shows after edge 8.
    task automatic startPhase(input string tag);
        int n;
        n = 0;
        rdSeq.delete();
        load = 1'b1;
        while (n < WAIT_MAX) begin
            tick();
            n++;
            if (ram_rd === 1'b1) rdSeq.push_back(ram_addr);
            if (din_ready === 1'b1) break;
        end
        check(tag, n, 8);
    endtask

    task automatic sendWord(input logic [15:0] w);
        int guard;
        guard = 0;
        while (din_ready !== 1'b1 && guard < WAIT_MAX) begin
            tick();
            guard++;
        end
        if (guard == WAIT_MAX) check("send_ready_timeout", din_ready, 1);
        exp_q.push_back({expWp, w[15:8]});
        exp_q.push_back({expWp + 16'd1, w[7:0]});
        expWp = expWp + 16'd2;
        Din       = w;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_din_ready"},     din_ready, 0);
        check({tag, "_ram_rd"},        ram_rd, 0);
        check({tag, "_ram_wr"},        ram_wr, 0);
        check({tag, "_param_done"},    param_done, 0);
        check({tag, "_ram_addr"},      ram_addr, 0);
        check({tag, "_ram_wdata"},     ram_wdata, 0);
        check({tag, "_num_layers"},    num_layers, 0);
        check({tag, "_words_written"}, words_written, 0);
        check({tag, "_in_dense"},      in_dense, 0);
        check({tag, "_err_overflow"},  err_overflow, 0);
        check({tag, "_state"},         32'(dbgState), 32'(S_IDLE));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int act;
        RST = 1'b1; load = 1'b0; cnn = 1'b0; Din = 16'd0; din_valid = 1'b0;
        pokeEn = 1'b0; pokeAddr = 16'd0; pokeData = 8'd0;
        repeat (3) tick();
        checkResetOutputs("reset");
        RST = 1'b0;
        tick();

        // Header: 3 layers, filter offset 0x000B, dense offset 0x0623.
        poke(16'd1, 8'd3);
        poke(16'd2, 8'h00);
        poke(16'd3, 8'h0B);
        poke(16'd4, 8'h06);
        poke(16'd5, 8'h23);

        // Image mode: nothing moves.
        load = 1'b1; cnn = 1'b0; act = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ram_rd || ram_wr || din_ready) act++;
        end
        check("image_mode_activity", act, 0);
        check("image_mode_state", 32'(dbgState), 32'(S_IDLE));
        load = 1'b0; cnn = 1'b1;
        repeat (2) tick();

        // Header read
        startPhase("hdr_ready_latency");
        check("hdr_rd_count", rdSeq.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < rdSeq.size()) check("hdr_rd_addr", rdSeq[i], HDR_BASE + i);
        end
        check("hdr_num_layers", num_layers, 3);
        check("hdr_in_dense", in_dense, 0);
        check("hdr_words_written", words_written, 0);

        // Single word 0xA55A
        exp_q.push_back({16'h000B, 8'hA5});
        exp_q.push_back({16'h000C, 8'h5A});
        Din = 16'hA55A; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        check("w1_hi_wr", ram_wr, 1);
        check("w1_hi_addr", ram_addr, 16'h000B);
        check("w1_hi_data", ram_wdata, 8'hA5);
        check("w1_ready_low1", din_ready, 0);
        tick();
        check("w1_lo_addr", ram_addr, 16'h000C);
        check("w1_lo_data", ram_wdata, 8'h5A);
        check("w1_ready_low2", din_ready, 0);
        tick();
        check("w1_ready_back", din_ready, 1);
        check("w1_words", words_written, 1);
        check("w1_mem_hi", mem[16'h000B], 8'hA5);
        check("w1_mem_lo", mem[16'h000C], 8'h5A);

        // Stream up to the dense boundary: 780 words total from 0x000B.
        expWp = 16'h000D;
        for (int i = 2; i <= 779; i++) sendWord(16'(i * 7 + 16'h0100));
        check("dense_before", in_dense, 0);
        check("dense_words_779", words_written, 779);
        exp_q.push_back({16'h0621, 8'h12});
        exp_q.push_back({16'h0622, 8'h34});
        Din = 16'h1234; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        check("dense_wrhi", in_dense, 0);
        tick();
        check("dense_wrlo", in_dense, 0);
        tick();
        check("dense_reached", in_dense, 1);
        check("dense_words_780", words_written, 780);
        exp_q.push_back({16'h0623, 8'hBE});
        exp_q.push_back({16'h0624, 8'hEF});
        Din = 16'hBEEF; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        check("dense_next_hi_addr", ram_addr, 16'h0623);
        tick();
        check("dense_next_lo_addr", ram_addr, 16'h0624);
        tick();
        check("dense_words_781", words_written, 781);
        check("dense_still", in_dense, 1);

        // End of phase from READY
        load = 1'b0;
        tick();
        check("end_done_pulse", param_done, 1);
        check("end_done_state", 32'(dbgState), 32'(S_DONE));
        tick();
        check("end_done_clear", param_done, 0);
        check("end_idle", 32'(dbgState), 32'(S_IDLE));
        check("end_exp_q_empty", exp_q.size(), 0);
        repeat (2) tick();

        // load drops during WR_HI: low byte still written, then DONE.
        startPhase("abort_ready_latency");
        check("abort_words_cleared", words_written, 0);
        exp_q.push_back({16'h000B, 8'h13});
        exp_q.push_back({16'h000C, 8'h57});
        Din = 16'h1357; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        load = 1'b0;
        tick();
        check("abort_lo_wr", ram_wr, 1);
        check("abort_lo_addr", ram_addr, 16'h000C);
        check("abort_lo_data", ram_wdata, 8'h57);
        tick();
        check("abort_done_pulse", param_done, 1);
        check("abort_words", words_written, 1);
        tick();
        check("abort_done_clear", param_done, 0);
        repeat (2) tick();

        // load drops during header read.
        load = 1'b1;
        repeat (3) tick();
        check("hdr_abort_state", 32'(dbgState), 32'(S_HDR_RD));
        load = 1'b0;
        tick();
        check("hdr_abort_done", param_done, 1);
        check("hdr_abort_words", words_written, 0);
        check("hdr_abort_rd", ram_rd, 0);
        tick();
        check("hdr_abort_clear", param_done, 0);
        repeat (2) tick();

        // RST during WR_HI: outputs clear without a clock edge.
        startPhase("rst_ready_latency");
        Din = 16'h2468; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        check("rst_in_wrhi", ram_wr, 1);
        RST = 1'b1;
        #1;
        checkResetOutputs("rst_mid");
        load = 1'b0;
        tick();
        RST = 1'b0;
        repeat (2) tick();

        // Overflow: filter offset 0xFFFE, two words offered.
        poke(16'd2, 8'hFF);
        poke(16'd3, 8'hFE);
        startPhase("ovf_ready_latency");
        check("ovf_in_dense_latched", in_dense, 1);
        check("ovf_err_clear", err_overflow, 0);
        exp_q.push_back({16'hFFFE, 8'h11});
        exp_q.push_back({16'hFFFF, 8'h22});
        Din = 16'h1122; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        check("ovf_hi_addr", ram_addr, 16'hFFFE);
        tick();
        check("ovf_lo_addr", ram_addr, 16'hFFFF);
        check("ovf_lo_wr", ram_wr, 1);
        tick();
        check("ovf_flag", err_overflow, 1);
        check("ovf_state", 32'(dbgState), 32'(S_ERR));
        check("ovf_ready_low", din_ready, 0);
        check("ovf_words", words_written, 1);
        Din = 16'h3344; din_valid = 1'b1; act = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (ram_wr || din_ready) act++;
        end
        din_valid = 1'b0;
        check("ovf_no_more_writes", act, 0);
        load = 1'b0;
        tick();
        check("ovf_done_pulse", param_done, 1);
        tick();
        check("ovf_done_clear", param_done, 0);
        check("ovf_flag_sticky", err_overflow, 1);
        check("ovf_mem_fffe", mem[16'hFFFE], 8'h11);
        check("ovf_mem_ffff", mem[16'hFFFF], 8'h22);
        check("ovf_exp_q_empty", exp_q.size(), 0);

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
